// File: rtl/tesla_pp_driver.sv
// Push-pull Tesla / half-bridge gate driver with button-tuned half-period.
// Ports: clk, rst_n (async active-low), btn_up_n/btn_down_n (async, active-low buttons),
//   enable, led_led (event toggle), led_tesla (first half marker), led_pp1/led_pp2
//   (complementary gates with dead time), half_period (active half-period probe).
// Optional interrupter mode: define TESLA_BURST_EN (adds BURST_ON / BURST_OFF).
module tesla_pp_driver #(
  parameter int CNT_W     = 16,
  parameter int HALF_INIT = 1654,
  parameter int HALF_MIN  = 100,
  parameter int HALF_MAX  = 50000,
  parameter int STEP      = 16,
  parameter int DEAD      = 5,
  parameter int DEB_CYC   = 1000000,
  parameter int REP_CYC   = 12500000
`ifdef TESLA_BURST_EN
  ,
  parameter int BURST_ON  = 8,
  parameter int BURST_OFF = 24
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up_n,
  input  logic             btn_down_n,
  input  logic             enable,
  output logic             led_led,
  output logic             led_tesla,
  output logic             led_pp1,
  output logic             led_pp2,
  output logic [CNT_W-1:0] half_period
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int RW = $clog2(REP_CYC + 1);
  localparam logic [CNT_W-1:0] INIT_V    = CNT_W'(HALF_INIT);
  localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(HALF_MIN);
  localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(HALF_MAX);
  localparam logic [CNT_W:0]   MIN_X     = (CNT_W+1)'(HALF_MIN);
  localparam logic [CNT_W:0]   MAX_X     = (CNT_W+1)'(HALF_MAX);
  localparam logic [CNT_W:0]   STEP_X    = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] DEAD_P1   = CNT_W'(DEAD + 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

  // ---------------- button debounce: index 0 = up, 1 = down ----------------
  logic [1:0]    btn_raw;
  logic [1:0]    sync1, sync2, lvl, ev;
  logic [DW-1:0] dcnt [2];
  logic [RW-1:0] rcnt [2];

  assign btn_raw = {btn_down_n, btn_up_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      lvl   <= 2'b11;
      ev    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        dcnt[i] <= '0;
        rcnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        ev[i] <= 1'b0;
        // Auto-repeat runs while the accepted level is low, including the
        // debounce window of a release.
        if (!lvl[i]) begin
          if (rcnt[i] == RW'(REP_CYC - 1)) begin
            rcnt[i] <= '0;
            ev[i]   <= 1'b1;
          end else begin
            rcnt[i] <= rcnt[i] + RW'(1);
          end
        end
        if (sync2[i] != lvl[i]) begin
          if (dcnt[i] == DW'(DEB_CYC - 1)) begin
            lvl[i]  <= sync2[i];
            dcnt[i] <= '0;
            rcnt[i] <= '0;
            if (!sync2[i]) ev[i] <= 1'b1;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // ---------------- pending half-period (saturating, CNT_W+1 wide math) ------
  logic [CNT_W-1:0] pend;
  logic [CNT_W:0]   pend_up, pend_dn;

  assign pend_up = {1'b0, pend} - STEP_X;
  assign pend_dn = {1'b0, pend} + STEP_X;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= INIT_V;
      led_led <= 1'b0;
    end else begin
      if (ev[0] && ev[1])
        pend <= INIT_V;
      else if (ev[0])
        pend <= (pend_up[CNT_W] || pend_up < MIN_X) ? MIN_V : pend_up[CNT_W-1:0];
      else if (ev[1])
        pend <= (pend_dn > MAX_X) ? MAX_V : pend_dn[CNT_W-1:0];
      if (ev[0] || ev[1]) led_led <= ~led_led;
    end
  end

  // ---------------- bridge FSM ----------------
  typedef enum logic [2:0] {IDLE, PH_A, DEAD_A, PH_B, DEAD_B} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, ph_last;
  logic             load;
  logic             run_ok;       // IDLE may start a period
  logic             wrap_to_idle; // burst complete at end of DEAD_B

  assign ph_last = half_period - DEAD_P1;

`ifdef TESLA_BURST_EN
  localparam int BW = $clog2(BURST_ON + 1);
  localparam int OW = CNT_W + $clog2(2 * BURST_OFF + 1);
  logic [BW-1:0] burst_cnt;
  logic [OW-1:0] off_cnt, off_last;
  logic          in_off;

  assign off_last     = OW'(half_period) * OW'(2 * BURST_OFF) - OW'(1);
  assign run_ok       = !in_off || (off_cnt == off_last);
  assign wrap_to_idle = (burst_cnt == BW'(BURST_ON - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      off_cnt   <= '0;
      in_off    <= 1'b0;
    end else if (!enable) begin
      burst_cnt <= '0;
      off_cnt   <= '0;
      in_off    <= 1'b0;
    end else begin
      if (state == DEAD_B && state_nx == IDLE) begin
        burst_cnt <= '0;
        off_cnt   <= '0;
        in_off    <= 1'b1;
      end else if (state == DEAD_B && state_nx == PH_A) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
      if (state == IDLE && in_off) begin
        if (off_cnt == off_last) begin
          in_off  <= 1'b0;
          off_cnt <= '0;
        end else begin
          off_cnt <= off_cnt + OW'(1);
        end
      end
    end
  end
`else
  assign run_ok       = 1'b1;
  assign wrap_to_idle = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (enable && run_ok) begin
        state_nx = PH_A;
        load     = 1'b1;
      end
      PH_A: if (!enable || cnt == ph_last) state_nx = DEAD_A;
      DEAD_A: if (cnt == DEAD_LAST) begin
        if (enable) begin
          state_nx = PH_B;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      PH_B: if (!enable || cnt == ph_last) state_nx = DEAD_B;
      DEAD_B: if (cnt == DEAD_LAST) begin
        if (enable && !wrap_to_idle) begin
          state_nx = PH_A;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      half_period <= INIT_V;
      led_pp1     <= 1'b0;
      led_pp2     <= 1'b0;
      led_tesla   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= (state_nx != state || state_nx == IDLE) ? '0 : cnt + CNT_W'(1);
      // Retune only at phase entry so a running phase never gets a runt.
      if (load) half_period <= pend;
      led_pp1   <= (state_nx == PH_A);
      led_pp2   <= (state_nx == PH_B);
      led_tesla <= (state_nx == PH_A) || (state_nx == DEAD_A);
    end
  end

endmodule
